pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Output-side counterpart to the input synchronizer flip-flop. It takes an internal, already-synchronous event signal and drives a human- or off-chip-visible output pulse of guaranteed width.
- Each rising edge of `in` produces exactly one `out` pulse lasting HOLD_CYCLES cycles, followed by at least GAP_CYCLES low cycles.
- One request is buffered. Further overflow is counted.
- Typical use: sits between core logic and LED/GPIO pins.

Parameters:
HOLD_CYCLES, 8, cycles `out` stays high per pulse; legal values >= 1
GAP_CYCLES, 2, minimum low cycles between pulses; legal values >= 0
DROP_W, 8, width of the dropped-request counter

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-low reset
in  input  1  synchronous event level; each 0->1 transition is one request
out  output  1  stretched pulse; registered
busy  output  1  high when the FSM is not IDLE or a request is pending; registered
drop_cnt  output  DROP_W  count of discarded requests; saturating; registered

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, out=0, busy=0, pending=0, drop_cnt=0, counter=0.
  - in_q=1, so a level already high when reset releases is not a request.
- Edge detect: `ev = in & ~in_q`, with in_q registered every cycle. A held-high `in` yields exactly one request.
- State IDLE (out=0):
  - On ev, go to HOLD and load counter=HOLD_CYCLES-1.
  - out=1 from that same edge. Latency is one clock from `in` rising to `out` rising.
- State HOLD (out=1):
  - Decrement counter each cycle.
  - When counter==0:
    - If GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES-1.
    - Otherwise, if a request is pending (or ev occurs this cycle), reload HOLD and clear pending; if not, go to IDLE.
  - `out` is high for exactly HOLD_CYCLES consecutive cycles per request.
- State GAP (out=0):
  - Decrement counter each cycle.
  - When counter==0: if pending or ev, go to HOLD (load HOLD_CYCLES-1) and clear pending; otherwise go to IDLE.
- ev while in HOLD or GAP and not consumed by a transition that same cycle:
  - If pending==0, set pending=1.
  - Otherwise discard the request and increment drop_cnt, saturating at 2^DROP_W-1 with no wrap.
- Simultaneous ev and end of HOLD/GAP: the ev is consumed directly by the transition. It neither sets pending nor drops.
- If pending==1, the pending request and ev arrive at the same end-of-phase edge: the pending request is serviced, and the ev becomes the new pending request. No drop occurs.
- busy = (state!=IDLE) | pending.
- Reset mid-operation: all outputs take reset values on that edge. In-flight and pending requests are lost and not counted.
- Counter width: $clog2 of max(HOLD_CYCLES, GAP_CYCLES, 2).

Optional Feature:
Macro: PULSE_STRETCH_RETRIGGER_EN
- Defined: ev during HOLD reloads counter=HOLD_CYCLES-1 and stays in HOLD. It neither pends nor drops. ev during GAP still follows the pending/drop rules.
- Undefined: HOLD is never extended. Behaviour is exactly as specified above.

Decomposition:
- Package pulse_stretch_pkg holds:
  - `stretch_state_t` enum {IDLE, HOLD, GAP}, 2-bit logic.
  - DROP_W default constant.
- Sub-module rise_detect (in, clk, reset -> ev): one register plus AND. Its reset value is 1 to match the in_q rule above.
- FSM, counter, pending flag and drop counter stay in pulse_stretcher.

Test Plan:
(HOLD_CYCLES=4, GAP_CYCLES=2, DROP_W=8, CLOCK_PERIOD=100)
- Reset: reset=0 for 2 cycles with in=1, then reset=1 with in still high -> out=0, busy=0, drop_cnt=0 throughout. No pulse is produced.
- Single request: in 0->1 sampled at edge N -> out=1 after edges N..N+3 and out=0 at N+4. busy=1 until edge N+6, then 0.
- Held input: in high for 12 cycles -> exactly one 4-cycle out pulse, drop_cnt=0.
- Overflow: three rising edges during one HOLD -> out pattern is 4 high, 2 low, 4 high, 2 low, then idle. drop_cnt=1.
- Reset mid-HOLD: reset=0 at 2nd high cycle -> out=0 and busy=0 on that edge. No further pulse after release.
- With PULSE_STRETCH_RETRIGGER_EN: a second rising edge sampled after 2 high cycles -> out high 6 consecutive cycles, then 2 low. drop_cnt=0.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher: FSM state encoding,
// the default drop-counter width and the counter sizing helper.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  localparam int DROP_W_DEFAULT = 8;

  // Phase counter must hold HOLD_CYCLES-1 and GAP_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = 2;
    if (hold > m) m = hold;
    if (gap > m) m = gap;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / pulse-out bundle between core logic and the pulse stretcher.
// The slave side is the stretcher; the master side is whoever raises events.
interface pulse_stretcher_if
  import pulse_stretch_pkg::*;
#(
  parameter int DROP_W = DROP_W_DEFAULT
);
  logic              in;
  logic              out;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport slave (
    input  in,
    output out,
    output busy,
    output drop_cnt
  );

  modport master (
    output in,
    input  out,
    input  busy,
    input  drop_cnt
  );
endinterface

// File: rtl/pulse_stretcher_rise_detect.sv
// Rising-edge detector: one register plus AND. The register resets high so a
// level already asserted when reset releases does not count as an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_ev
);
  logic r_inQ;

  always_ff @(posedge clk) begin
    if (!reset) r_inQ <= 1'b1;
    else        r_inQ <= i_in;
  end

  assign o_ev = i_in & ~r_inQ;
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches each rising edge of bus.in into one HOLD_CYCLES-wide pulse plus a
// GAP_CYCLES low gap, with one buffered request. Option: PULSE_STRETCH_RETRIGGER_EN.
module pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int DROP_W      = DROP_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  pulse_stretcher_if.slave    bus
);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  stretch_state_t    r_state, w_stateNext;
  logic [CW-1:0]     r_cnt, w_cntNext;
  logic              r_pending, w_pendNext;
  logic              r_out, r_busy;
  logic [DROP_W-1:0] r_dropCnt;
  logic              w_ev, w_evQueue, w_dropInc;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .i_in  (bus.in),
    .o_ev  (w_ev)
  );

  // w_evQueue marks an event that no transition consumed this cycle.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_pendNext  = r_pending;
    w_evQueue   = 1'b0;
    w_dropInc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ev) begin
          w_stateNext = HOLD;
          w_cntNext   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (RETRIGGER && w_ev) begin
          w_cntNext = HOLD_LOAD;
        end else if (r_cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            w_stateNext = GAP;
            w_cntNext   = GAP_LOAD;
            w_evQueue   = w_ev;
          end else if (r_pending || w_ev) begin
            w_cntNext  = HOLD_LOAD;
            w_pendNext = r_pending & w_ev;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_cntNext = r_cnt - 1'b1;
          w_evQueue = w_ev;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          if (r_pending || w_ev) begin
            w_stateNext = HOLD;
            w_cntNext   = HOLD_LOAD;
            w_pendNext  = r_pending & w_ev;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_cntNext = r_cnt - 1'b1;
          w_evQueue = w_ev;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
        w_pendNext  = 1'b0;
      end
    endcase
    if (w_evQueue) begin
      if (!r_pending) w_pendNext = 1'b1;
      else            w_dropInc  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_dropCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_pending <= w_pendNext;
      r_out     <= (w_stateNext == HOLD);
      r_busy    <= (w_stateNext != IDLE) | w_pendNext;
      if (w_dropInc && (r_dropCnt != {DROP_W{1'b1}}))
        r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  assign bus.out      = r_out;
  assign bus.busy     = r_busy;
  assign bus.drop_cnt = r_dropCnt;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (HOLD=4, GAP=2, DROP_W=8); the
// retrigger scenario follows PULSE_STRETCH_RETRIGGER_EN when defined.
module tb_pulse_stretcher;
  localparam int HOLD   = 4;
  localparam int GAPC   = 2;
  localparam int DW     = 8;
  localparam int PERIOD = 100;

  typedef struct {
    logic  expOut;
    logic  expBusy;
    string tag;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sbQ[$];

  pulse_stretcher_if #(.DROP_W(DW)) bus ();

  pulse_stretcher #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAPC),
    .DROP_W      (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Drive one cycle, queue the expected registered outputs, compare after the edge.
  task automatic step(input logic inVal, input logic rstVal,
                      input logic expOut, input logic expBusy, input string tag);
    exp_t e;
    exp_t got;
    bus.in = inVal;
    reset  = rstVal;
    e.expOut  = expOut;
    e.expBusy = expBusy;
    e.tag     = tag;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checks++;
    if (bus.out !== got.expOut) begin
      errors++;
      $display("[TB] FAIL %s out: got %b expected %b", got.tag, bus.out, got.expOut);
    end
    checks++;
    if (bus.busy !== got.expBusy) begin
      errors++;
      $display("[TB] FAIL %s busy: got %b expected %b", got.tag, bus.busy, got.expBusy);
    end
  endtask

  task automatic test_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, "reset_hold");
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, "reset_release_high");
    step(1'b0, 1'b1, 1'b0, 1'b0, "reset_in_low");
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset drop_cnt: got %0d expected 0", bus.drop_cnt);
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b1, 1'b1, 1'b1, "single_rise");
    step(1'b0, 1'b1, 1'b1, 1'b1, "single_hold");
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, "single_hold");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, "single_gap");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, "single_idle");
  endtask

  task automatic test_held();
    for (int i = 0; i < 12; i++) begin
      if (i < 4)      step(1'b1, 1'b1, 1'b1, 1'b1, "held_hold");
      else if (i < 6) step(1'b1, 1'b1, 1'b0, 1'b1, "held_gap");
      else            step(1'b1, 1'b1, 1'b0, 1'b0, "held_idle");
    end
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, "held_low");
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL held drop_cnt: got %0d expected 0", bus.drop_cnt);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b1, 1'b1, 1'b1, "ovf_first");
    step(1'b0, 1'b1, 1'b1, 1'b1, "ovf_hold");
    step(1'b1, 1'b1, 1'b1, 1'b1, "ovf_pend");
    step(1'b0, 1'b1, 1'b1, 1'b1, "ovf_hold");
    step(1'b1, 1'b1, 1'b0, 1'b1, "ovf_drop");
    step(1'b0, 1'b1, 1'b0, 1'b1, "ovf_gap");
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1, "ovf_second_pulse");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, "ovf_gap2");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, "ovf_idle");
    checks++;
    if (bus.drop_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL overflow drop_cnt: got %0d expected 1", bus.drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b1, 1'b1, "rstmid_start");
    step(1'b0, 1'b0, 1'b0, 1'b0, "rstmid_assert");
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rstmid drop_cnt: got %0d expected 0", bus.drop_cnt);
    end
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, "rstmid_after");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 1'b1, 1'b1, "b2b_first");
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, "b2b_hold");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, "b2b_gap");
    step(1'b1, 1'b1, 1'b1, 1'b1, "b2b_gap_end_rise");
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, "b2b_hold2");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, "b2b_gap2");
    step(1'b0, 1'b1, 1'b0, 1'b0, "b2b_idle");
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL b2b drop_cnt: got %0d expected 0", bus.drop_cnt);
    end
  endtask

  task automatic test_retrigger();
    step(1'b1, 1'b1, 1'b1, 1'b1, "retrig_first");
    step(1'b0, 1'b1, 1'b1, 1'b1, "retrig_hold");
    step(1'b1, 1'b1, 1'b1, 1'b1, "retrig_second");
`ifdef PULSE_STRETCH_RETRIGGER_EN
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, "retrig_extended");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, "retrig_gap");
    step(1'b0, 1'b1, 1'b0, 1'b0, "retrig_idle");
`else
    step(1'b0, 1'b1, 1'b1, 1'b1, "retrig_hold");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, "retrig_gap");
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1, "retrig_pended_pulse");
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, "retrig_gap2");
    step(1'b0, 1'b1, 1'b0, 1'b0, "retrig_idle");
`endif
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL retrig drop_cnt: got %0d expected 0", bus.drop_cnt);
    end
  endtask

  task automatic test_saturation();
    int waitCnt;
    reset = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      bus.in = i[0];
      @(posedge clk);
      #1;
    end
    bus.in  = 1'b0;
    waitCnt = 0;
    while (bus.busy === 1'b1 && waitCnt < 40) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_drain busy: got %b expected 0 within 40 cycles", bus.busy);
    end
    checks++;
    if (bus.drop_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat drop_cnt: got %0d expected 255", bus.drop_cnt);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, "sat_idle");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in = 1'b1;
    reset  = 1'b0;
    #(PERIOD/4);
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_retrigger();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
